afe_tot_meas: RTL

//  Measurement stage directly downstream of the AFE comparator, inside afe_main.

---
 rtl/afe_tot_meas_pkg.sv | 28 ++
 rtl/afe_tot_meas_if.sv | 27 ++
 rtl/afe_tot_meas_sync.sv | 35 +++
 rtl/afe_tot_meas.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/afe_tot_meas_pkg.sv
// Shared definitions for the AFE time-over-threshold measurement stage:
// FSM state encoding, default parameters and the SPI readout status order.
`timescale 1ns/1ps
package afe_tot_meas_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_COMP = 2'd1,
    S_MEASURE   = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF     = 255;

  // Status nibble as shifted out by the SPI readout: {VALID,OVF,TMO,BUSY},
  // followed on the wire by DELAY and then TOT.
  localparam int STATUS_W = 4;

  function automatic logic [STATUS_W-1:0] pack_status(input logic valid,
                                                      input logic ovf,
                                                      input logic tmo,
                                                      input logic busy);
    return {valid, ovf, tmo, busy};
  endfunction

endpackage

// File: rtl/afe_tot_meas_if.sv
// Signal bundle between the comparator front end / SPI decode and the
// measurement stage. The slave side is the measurement block.
`timescale 1ns/1ps
interface afe_tot_meas_if #(
  parameter int CNT_W = 8
);
  logic             inj;
  logic             comp;
  logic             arm;
  logic             hit;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] tot;
  logic             valid;
  logic             ovf;
  logic             tmo;
  logic             busy;

  modport master (
    output inj, comp, arm,
    input  hit, delay, tot, valid, ovf, tmo, busy
  );

  modport slave (
    input  inj, comp, arm,
    output hit, delay, tot, valid, ovf, tmo, busy
  );
endinterface

// File: rtl/afe_tot_meas_sync.sv
// Multi-flop synchroniser for an asynchronous pad signal with registered
// one-cycle rising and falling edge pulses. Both pulses appear
// SYNC_STAGES+1 clock edges after the pad edge is first sampled.
`timescale 1ns/1ps
module afe_tot_meas_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Shift the pad level through the synchroniser and register edge pulses.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      last_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~last_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & last_q;
    end
  end

endmodule

// File: rtl/afe_tot_meas.sv
// Injection-to-threshold delay and time-over-threshold measurement.
// One shared counter serves both phases; results are held until ARM.
`timescale 1ns/1ps
module afe_tot_meas
  import afe_tot_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  afe_tot_meas_if.slave bus
);

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0] TMO_LIM = (CNT_W+1)'(TIMEOUT);

  logic inj_re;
  logic inj_fe_unused;
  logic comp_re;
  logic comp_fe;

  state_t           state_q, state_d;
  logic [CNT_W:0]   cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] tot_q, tot_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic             hit_q, hit_d;
  logic             busy_q, busy_d;

  afe_tot_meas_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inj (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.inj),
    .rise (inj_re),
    .fall (inj_fe_unused)
  );

  afe_tot_meas_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_comp (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.comp),
    .rise (comp_re),
    .fall (comp_fe)
  );

  // The counter is one bit wider than the results so a count past the
  // result range is still visible for saturation and OVF.
  assign cnt_inc = cnt_q + 1'b1;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W:0] v);
    return (v > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : v[CNT_W-1:0];
  endfunction

  // Next-state, counter and result update; ARM overrides every edge event.
  // NOTE: every variable gets its hold value before the case statement so
  // no path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    tot_d   = tot_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    hit_d   = 1'b0;

    if (bus.arm) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      delay_d = '0;
      tot_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      tmo_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A comparator edge without (or together with) injection is a hit.
          if (comp_re) begin
            state_d = S_MEASURE;
            cnt_d   = '0;
            delay_d = '0;
            hit_d   = 1'b1;
          end else if (inj_re) begin
            state_d = S_WAIT_COMP;
            cnt_d   = '0;
          end
        end
        S_WAIT_COMP: begin
          if (comp_re) begin
            state_d = S_MEASURE;
            cnt_d   = '0;
            delay_d = sat(cnt_inc);
            ovf_d   = (cnt_inc > CNT_MAX);
            hit_d   = 1'b1;
          end else if (cnt_inc >= TMO_LIM) begin
            state_d = S_DONE;
            cnt_d   = cnt_inc;
            delay_d = sat(TMO_LIM);
            tot_d   = '0;
            valid_d = 1'b1;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_MEASURE: begin
          if (comp_fe) begin
            state_d = S_DONE;
            tot_d   = sat(cnt_inc);
            ovf_d   = ovf_q | (cnt_inc > CNT_MAX);
            valid_d = 1'b1;
          end else if (cnt_q <= CNT_MAX) begin
            cnt_d = cnt_inc;
          end
        end
        S_DONE: begin
          // Results hold; edges are ignored until re-armed.
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_WAIT_COMP) || (state_d == S_MEASURE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      tot_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      tot_q   <= tot_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.hit   = hit_q;
  assign bus.delay = delay_q;
  assign bus.tot   = tot_q;
  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;
  assign bus.tmo   = tmo_q;
  assign bus.busy  = busy_q;

endmodule
